// File: rtl/hack_screen_scanner_if.sv
// Port-B link between the screen scanner and the dual-port Hack screen buffer.
// Read-only port B. There is no handshake and no stall: an address driven in cycle N returns its word on scr_data in cycle N+1.
interface hack_screen_scanner_if;
  logic [12:0] scr_addr;
  logic        scr_load;
  logic [15:0] scr_in;
  logic [15:0] scr_data;

  modport master (
    output scr_addr,
    output scr_load,
    output scr_in,
    input  scr_data
  );

  modport slave (
    input  scr_addr,
    input  scr_load,
    input  scr_in,
    output scr_data
  );
endinterface

// File: rtl/hack_screen_scanner.sv
// Raster generator and pixel serializer for the 512x256 Hack screen buffer.
// Each output trails its raster counter position by exactly two clocks.
module hack_screen_scanner #(
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  hack_screen_scanner_if.master  scr,
  output logic                   pixel,
  output logic                   de,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
);

  localparam int H_ACTIVE = 512;
  localparam int V_ACTIVE = 256;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [12:0]   addr_q, addr_d;
  logic          load_q, load_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [1:0]    de_pipe_q, de_pipe_d;
  logic [1:0]    hs_pipe_q, hs_pipe_d;
  logic [1:0]    vs_pipe_q, vs_pipe_d;
  logic [1:0]    fs_pipe_q, fs_pipe_d;

  logic h_wrap;
  logic v_wrap;
  logic active;
  logic fetch;
  logic hsync_raw;
  logic vsync_raw;
  logic fs_raw;

  // Raster position decode; everything here describes the counter position,
  // not the output position.
  always_comb begin
    h_wrap    = (hcount_q == H_LAST);
    v_wrap    = (vcount_q == V_LAST);
    active    = (hcount_q < H_ACT_END) && (vcount_q < V_ACT_END);
    fetch     = active && (hcount_q[3:0] == 4'd0);
    hsync_raw = (hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END);
    vsync_raw = (vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END);
    fs_raw    = (hcount_q == '0) && (vcount_q == '0);
  end

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (h_wrap) begin
      hcount_d = '0;
      vcount_d = v_wrap ? '0 : vcount_q + VW'(1);
    end else begin
      hcount_d = hcount_q + HW'(1);
    end
  end

  // The address is live in the fetch cycle and held in between, so the
  // buffer sees a stable address through blanking.
  always_comb begin
    addr_d = addr_q;
    if (fetch) begin
      addr_d = {vcount_q[7:0], hcount_q[8:4]};
    end
  end

  // scr_data is only meaningful the cycle after a fetch; that cycle reloads
  // the shifter, every other cycle shifts toward bit 0 (leftmost pixel first).
  always_comb begin
    load_d  = fetch;
    shreg_d = {1'b0, shreg_q[15:1]};
    if (load_q) begin
      shreg_d = scr.scr_data;
    end
  end

  always_comb begin
    de_pipe_d = {de_pipe_q[0], active};
    hs_pipe_d = {hs_pipe_q[0], hsync_raw};
    vs_pipe_d = {vs_pipe_q[0], vsync_raw};
    fs_pipe_d = {fs_pipe_q[0], fs_raw};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      addr_q    <= '0;
      load_q    <= 1'b0;
      shreg_q   <= '0;
      de_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      fs_pipe_q <= '0;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      addr_q    <= addr_d;
      load_q    <= load_d;
      shreg_q   <= shreg_d;
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
      fs_pipe_q <= fs_pipe_d;
    end
  end

  // The sync pipes carry "sync asserted", so a cleared pipe reads as the inactive level.
  always_comb begin
    scr.scr_addr = addr_d;
    scr.scr_load = 1'b0;
    scr.scr_in   = 16'h0000;
    de           = de_pipe_q[1];
    pixel        = de_pipe_q[1] & shreg_q[0];
    hsync        = hs_pipe_q[1] ? SYNC_POL : ~SYNC_POL;
    vsync        = vs_pipe_q[1] ? SYNC_POL : ~SYNC_POL;
    frame_start  = fs_pipe_q[1];
  end

endmodule

// File: tb/tb_hack_screen_scanner.sv
// Bench for hack_screen_scanner: screen-buffer model, pixel/address scoreboards
// and line-timing monitor, driven through two raster starts and a mid-frame reset.
module tb_hack_screen_scanner;

  localparam int H_TOTAL = 672;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pixel, de, hsync, vsync, frame_start;

  always #5 clock = ~clock;

  hack_screen_scanner_if bus ();

  hack_screen_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .scr         (bus),
    .pixel       (pixel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  logic [15:0] mem [8192];

  always @(posedge clock) bus.scr_data <= mem[bus.scr_addr];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [0:0]  exp_q[$];
  logic [12:0] addr_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:0] model_pixel(input int x, input int y);
    logic [15:0] w;
    w = mem[y * 32 + x / 16];
    return w[x % 16];
  endfunction

  task automatic push_lines(input int n);
    for (int y = 0; y < n; y++)
      for (int x = 0; x < 512; x++)
        exp_q.push_back(model_pixel(x, y));
    for (int a = 0; a < n * 32; a++)
      addr_q.push_back(13'(a));
  endtask

  // Pixel scoreboard: one pop per displayed pixel.
  int  mx = 0;
  int  my = 0;
  bit  pde_prev = 1'b0;
  logic [0:0] pe;
  always @(negedge clock) begin
    if (reset) begin
      mx = 0;
      my = 0;
      pde_prev = 1'b0;
    end else begin
      if (mon_en && de) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_underflow: got pixel with no expectation at %0t", $time);
        end else begin
          pe = exp_q.pop_front();
          check("pixel", int'(pixel), int'(pe));
        end
        check("frame_start", int'(frame_start), (mx == 0 && my == 0) ? 1 : 0);
      end
      if (de) mx++;
      if (pde_prev && !de) begin
        if (mon_en) check("pixel_blank", int'(pixel), 0);
        mx = 0;
        my++;
      end
      pde_prev = de;
    end
  end

  // Address scoreboard: one pop per new fetch address.
  int aprev = -1;
  int acyc = 0;
  int alast = 0;
  logic [12:0] ae;
  always @(negedge clock) begin
    acyc++;
    if (reset || !mon_en) begin
      aprev = -1;
    end else if (int'(bus.scr_addr) != aprev) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL addr_underflow: got addr %0d with no expectation", bus.scr_addr);
      end else begin
        ae = addr_q.pop_front();
        check("scr_addr", int'(bus.scr_addr), int'(ae));
      end
      if (bus.scr_addr[4:0] != 5'd0) check("addr_interval", acyc - alast, 16);
      aprev = int'(bus.scr_addr);
      alast = acyc;
    end
  end

  // Line timing measured at the outputs.
  bit tde_prev = 1'b0;
  bit ths_prev = 1'b1;
  int de_run = 0;
  int hs_run = 0;
  int gap = -1000;
  always @(negedge clock) begin
    if (reset || !mon_en) begin
      tde_prev = 1'b0;
      ths_prev = 1'b1;
      de_run = 0;
      hs_run = 0;
      gap = -1000;
    end else begin
      if (de) de_run++;
      if (tde_prev && !de) begin
        check("de_width", de_run, 512);
        check("vsync_idle", int'(vsync), 1);
        de_run = 0;
        gap = 0;
      end else begin
        gap++;
      end
      if (ths_prev && !hsync) check("hsync_delay", gap, 16);
      if (!hsync) hs_run++;
      if (!ths_prev && hsync) begin
        check("hsync_width", hs_run, 96);
        hs_run = 0;
      end
      tde_prev = de;
      ths_prev = hsync;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_scr_addr"}, int'(bus.scr_addr), 0);
  endtask

  localparam int K_RESET = 20 * H_TOTAL + 200;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h0001;
    mem[1]   = 16'h8000;
    mem[32]  = 16'hA5C3;
    mem[45]  = 16'h0F0F;
    mem[63]  = 16'h8001;
    mem[64]  = 16'hFFFF;
    mem[66]  = 16'h1234;
    mem[97]  = 16'h00F0;
    mem[640] = 16'h5555;
    mem[652] = 16'h0030;
    mem[8191] = 16'hFFFF;

    reset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("rst");
    check("rst_scr_load", int'(bus.scr_load), 0);
    check("rst_scr_in", int'(bus.scr_in), 0);

    push_lines(21);
    @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    @(negedge clock);
    check("lat0_de", int'(de), 0);
    @(negedge clock);
    check("lat1_de", int'(de), 0);
    check("lat1_frame_start", int'(frame_start), 0);
    @(negedge clock);
    check("first_de", int'(de), 1);
    check("first_frame_start", int'(frame_start), 1);
    check("first_pixel", int'(pixel), 1);

    repeat (K_RESET - 2) @(posedge clock);
    #1;
    mon_en = 1'b0;
    check("pre_reset_pix_left", exp_q.size(), 314);
    check("pre_reset_addr_left", addr_q.size(), 19);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    push_lines(2);
    mon_en = 1'b1;

    @(negedge clock);
    check_reset_outputs("mid");
    @(negedge clock);
    check("restart_de_early", int'(de), 0);
    check("restart_fs_early", int'(frame_start), 0);
    @(negedge clock);
    check("restart_frame_start", int'(frame_start), 1);
    check("restart_de", int'(de), 1);
    check("restart_pixel", int'(pixel), 1);

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clock);
    #1 mon_en = 1'b0;
    check("drain_pixels", exp_q.size(), 0);
    check("drain_addrs", addr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
